// File: rtl/bank_rd_agu_if.sv
// Control, bank read port and output stream of one bank read address generator.
// The slave modport is the generator's view; master is the controller/bank/consumer side.
interface bank_rd_agu_if #(
    parameter int BDADDR = 10,
    parameter int BDWORD = 64,
    parameter int BDCNT  = 10
);
    logic              start;
    logic [BDADDR-1:0] base_addr;
    logic [BDCNT-1:0]  in_len;
    logic [BDADDR-1:0] in_stride;
    logic [BDCNT-1:0]  out_len;
    logic [BDADDR-1:0] out_stride;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [BDADDR-1:0] rd_addr;
    logic [BDWORD-1:0] rd_word;
    logic              out_valid;
    logic              out_ready;
    logic [BDWORD-1:0] out_word;

    modport slave (
        input  start, base_addr, in_len, in_stride, out_len, out_stride, rd_word, out_ready,
        output busy, done, rd_en, rd_addr, out_valid, out_word
    );

    modport master (
        output start, base_addr, in_len, in_stride, out_len, out_stride, rd_word, out_ready,
        input  busy, done, rd_en, rd_addr, out_valid, out_word
    );
endinterface

// File: rtl/bank_rd_agu.sv
// 2-D strided read address generator for one data bank; absorbs the 1-cycle bank latency
// in a 2-entry output FIFO and streams words on valid/ready.
module bank_rd_agu #(
    parameter int BDADDR = 10,
    parameter int BDWORD = 64,
    parameter int BDCNT  = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    bank_rd_agu_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [BDCNT-1:0]  in_len_q, in_len_d, out_len_q, out_len_d;
    logic [BDCNT-1:0]  i_cnt_q, i_cnt_d, j_cnt_q, j_cnt_d;
    logic [BDADDR-1:0] in_stride_q, in_stride_d, out_stride_q, out_stride_d;
    logic [BDADDR-1:0] row_ptr_q, row_ptr_d, cur_ptr_q, cur_ptr_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        fifo_cnt_q, fifo_cnt_d;
    logic              rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [1:0][BDWORD-1:0] fifo_mem;

    logic       push, pop, rd_en, inner_last, outer_last;
    logic [2:0] occ;

    // Occupancy counts the word already in flight, so the FIFO can never overflow.
    always_comb begin
        push       = inflight_q;
        pop        = (fifo_cnt_q != 2'd0) && bus.out_ready;
        occ        = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
        rd_en      = (state_q == RUN) && (occ < 3'd2);
        inner_last = (i_cnt_q == in_len_q - BDCNT'(1));
        outer_last = (j_cnt_q == out_len_q - BDCNT'(1));
    end

    always_comb begin
        fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
        wr_ptr_d   = push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d   = pop  ? ~rd_ptr_q : rd_ptr_q;
        inflight_d = rd_en;
    end

    always_comb begin
        state_d      = state_q;
        in_len_d     = in_len_q;
        out_len_d    = out_len_q;
        in_stride_d  = in_stride_q;
        out_stride_d = out_stride_q;
        i_cnt_d      = i_cnt_q;
        j_cnt_d      = j_cnt_q;
        row_ptr_d    = row_ptr_q;
        cur_ptr_d    = cur_ptr_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    in_len_d     = bus.in_len;
                    out_len_d    = bus.out_len;
                    in_stride_d  = bus.in_stride;
                    out_stride_d = bus.out_stride;
                    i_cnt_d      = '0;
                    j_cnt_d      = '0;
                    row_ptr_d    = bus.base_addr;
                    cur_ptr_d    = bus.base_addr;
                    state_d      = ((bus.in_len != '0) && (bus.out_len != '0)) ? RUN : DONE;
                end
            end
            RUN: begin
                if (rd_en) begin
                    if (!inner_last) begin
                        i_cnt_d   = i_cnt_q + BDCNT'(1);
                        cur_ptr_d = cur_ptr_q + in_stride_q;
                    end else if (!outer_last) begin
                        i_cnt_d   = '0;
                        j_cnt_d   = j_cnt_q + BDCNT'(1);
                        row_ptr_d = row_ptr_q + out_stride_q;
                        cur_ptr_d = row_ptr_q + out_stride_q;
                    end else begin
                        // Pointer stays on the final address so rd_addr holds it.
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((fifo_cnt_d == 2'd0) && !inflight_q) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            in_len_q     <= '0;
            out_len_q    <= '0;
            in_stride_q  <= '0;
            out_stride_q <= '0;
            i_cnt_q      <= '0;
            j_cnt_q      <= '0;
            row_ptr_q    <= '0;
            cur_ptr_q    <= '0;
            inflight_q   <= 1'b0;
            fifo_cnt_q   <= 2'd0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_len_q     <= in_len_d;
            out_len_q    <= out_len_d;
            in_stride_q  <= in_stride_d;
            out_stride_q <= out_stride_d;
            i_cnt_q      <= i_cnt_d;
            j_cnt_q      <= j_cnt_d;
            row_ptr_q    <= row_ptr_d;
            cur_ptr_q    <= cur_ptr_d;
            inflight_q   <= inflight_d;
            fifo_cnt_q   <= fifo_cnt_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
            logic [BDWORD-1:0] entry_q, entry_d;
            always_comb begin
                entry_d = entry_q;
                if (push && (wr_ptr_q == 1'(gi))) entry_d = bus.rd_word;
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) entry_q <= '0;
                else        entry_q <= entry_d;
            end
            assign fifo_mem[gi] = entry_q;
        end
    endgenerate

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.rd_en     = rd_en;
    assign bus.rd_addr   = cur_ptr_q;
    assign bus.out_valid = (fifo_cnt_q != 2'd0);
    assign bus.out_word  = fifo_mem[rd_ptr_q];

endmodule
